spi_blink_ctrl: RTL

SPI_BLINK_CTRL -- requirements
Module: spi_blink_ctrl

---
 rtl/spi_blink_pkg.sv | 27 ++
 rtl/spi_blink_spi_if.sv | 105 ++++++++++
 rtl/spi_blink_ctrl.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/spi_blink_pkg.sv
// Shared constants for the SPI-controlled LED blinker: register map,
// reset values, the VERSION constant and the 10 ms tick divisor.
`timescale 1ns/1ps
package spi_blink_pkg;

   typedef enum logic [1:0] {
      REG_CTRL    = 2'd0,
      REG_PERIOD  = 2'd1,
      REG_PATTERN = 2'd2,
      REG_VERSION = 2'd3
   } reg_addr_t;

   localparam logic [7:0]  CTRL_RST    = 8'h01;   // enable=1, invert=0
   localparam logic [7:0]  PERIOD_RST  = 8'd50;   // 0.5 s half-period
   localparam logic [7:0]  VERSION_VAL = 8'hA5;
   localparam int unsigned TICK_HZ     = 100;     // 10 ms timebase

   // clk cycles per 10 ms tick; never below one so tiny clocks still tick
   function automatic int unsigned tick_div(input int unsigned clk_hz);
      int unsigned div;
      div = clk_hz / TICK_HZ;
      if (div < 1)
         div = 1;
      return div;
   endfunction

endpackage

// File: rtl/spi_blink_spi_if.sv
// SPI mode-0 slave front end: input synchronisers, edge detection,
// 16-bit frame shifting, write decode and read-shadow shifting on MISO.
`timescale 1ns/1ps
module spi_blink_spi_if
   import spi_blink_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       spi_sclk,
   input  logic       spi_cs_n,
   input  logic       spi_mosi,
   output logic       spi_miso,
   output logic       wr_valid,
   output logic [1:0] addr,
   output logic [7:0] wdata,
   output logic       rd_req,
   input  logic [7:0] rdata
);

   // bit 2 = cs_n, bit 1 = sclk, bit 0 = mosi
   logic [2:0]  meta_reg;
   logic [2:0]  sync_reg;
   logic        sclk_d_reg;
   logic        cs_d_reg;
   logic        active_reg;
   logic [4:0]  cnt_reg;
   logic [14:0] shift_reg;
   logic [7:0]  shadow_reg;
   logic        miso_reg;

   logic sclk_s, cs_s, mosi_s;
   logic sclk_rise, sclk_fall, cs_fall, cs_rise;
   logic bit_live;

   assign mosi_s = sync_reg[0];
   assign sclk_s = sync_reg[1];
   assign cs_s   = sync_reg[2];

   // Two-flop synchronisers. Resetting cs to 0 means a CS held low across
   // reset never looks like a falling edge, so a half-sent frame is dropped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_reg <= 3'b000;
         sync_reg <= 3'b000;
      end else begin
         meta_reg <= {spi_cs_n, spi_sclk, spi_mosi};
         sync_reg <= meta_reg;
      end
   end

   assign sclk_rise = sclk_s & ~sclk_d_reg;
   assign sclk_fall = ~sclk_s & sclk_d_reg;
   assign cs_fall   = ~cs_s & cs_d_reg;
   assign cs_rise   = cs_s & ~cs_d_reg;

   // a frame bit is accepted only inside an open frame and before the 16th edge
   assign bit_live = active_reg && (cnt_reg < 5'd16) && !cs_fall && !cs_rise;

   // 16th rising edge of a write frame: shift_reg holds frame[15:1], mosi is bit 0
   assign wr_valid = bit_live && sclk_rise && (cnt_reg == 5'd15) && !shift_reg[14];
   // 8th rising edge of a read frame: shift_reg[6:0] holds frame[15:9], mosi is bit 8
   assign rd_req   = bit_live && sclk_rise && (cnt_reg == 5'd7) && shift_reg[6];
   assign addr     = (cnt_reg == 5'd7) ? {shift_reg[0], mosi_s} : shift_reg[8:7];
   assign wdata    = {shift_reg[6:0], mosi_s};

   // MISO is forced low whenever the host deselects us
   assign spi_miso = miso_reg & ~spi_cs_n;

   // Frame tracking: bit counter, MOSI shift register and MISO read shadow
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sclk_d_reg <= 1'b0;
         cs_d_reg   <= 1'b0;
         active_reg <= 1'b0;
         cnt_reg    <= 5'd0;
         shift_reg  <= 15'd0;
         shadow_reg <= 8'd0;
         miso_reg   <= 1'b0;
      end else begin
         sclk_d_reg <= sclk_s;
         cs_d_reg   <= cs_s;
         if (cs_fall) begin
            active_reg <= 1'b1;
            cnt_reg    <= 5'd0;
            shift_reg  <= 15'd0;
            shadow_reg <= 8'd0;
            miso_reg   <= 1'b0;
         end else if (cs_rise) begin
            active_reg <= 1'b0;
            miso_reg   <= 1'b0;
         end else if (bit_live) begin
            if (sclk_rise) begin
               cnt_reg   <= cnt_reg + 5'd1;
               shift_reg <= {shift_reg[13:0], mosi_s};
               if (rd_req)
                  shadow_reg <= rdata;
            end else if (sclk_fall) begin
               miso_reg   <= shadow_reg[7];
               shadow_reg <= {shadow_reg[6:0], 1'b0};
            end
         end
      end
   end

endmodule

// File: rtl/spi_blink_ctrl.sv
// LED blinker controlled over SPI: register file (CTRL, PERIOD, PATTERN,
// VERSION), 10 ms prescaler, half-period counter and registered LED drive.
`timescale 1ns/1ps
module spi_blink_ctrl
   import spi_blink_pkg::*;
#(
   parameter int CLK_HZ = 21000000,
   parameter int LED_W  = 2
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             spi_sclk,
   input  logic             spi_cs_n,
   input  logic             spi_mosi,
   output logic             spi_miso,
   output logic [LED_W-1:0] led
);

   localparam int unsigned TICK_DIV = tick_div(CLK_HZ);
   localparam int          PRESC_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic       wr_valid, rd_req;
   logic [1:0] addr;
   logic [7:0] wdata, rdata;

   spi_blink_spi_if u_spi_if (
      .clk      (clk),
      .rst      (rst),
      .spi_sclk (spi_sclk),
      .spi_cs_n (spi_cs_n),
      .spi_mosi (spi_mosi),
      .spi_miso (spi_miso),
      .wr_valid (wr_valid),
      .addr     (addr),
      .wdata    (wdata),
      .rd_req   (rd_req),
      .rdata    (rdata)
   );

   logic               enable_reg, invert_reg;
   logic [7:0]         period_reg;
   logic [LED_W-1:0]   pattern_reg;
   logic [PRESC_W-1:0] presc_reg;
   logic [7:0]         hp_reg, hp_next;
   logic               phase_reg, phase_next;
   logic [LED_W-1:0]   led_reg;

   reg_addr_t reg_addr;
   logic      wr_ctrl, wr_period, wr_pattern;
   logic [7:0] pattern_ext;

   assign reg_addr   = reg_addr_t'(addr);
   assign wr_ctrl    = wr_valid && (reg_addr == REG_CTRL);
   assign wr_period  = wr_valid && (reg_addr == REG_PERIOD);
   assign wr_pattern = wr_valid && (reg_addr == REG_PATTERN);

   // unused PATTERN bits read back as zero
   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_pat
         if (gi < LED_W) begin : g_used
            assign pattern_ext[gi] = pattern_reg[gi];
         end else begin : g_zero
            assign pattern_ext[gi] = 1'b0;
         end
      end
   endgenerate

   // Register write port; VERSION has no storage so its writes vanish
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         enable_reg  <= CTRL_RST[0];
         invert_reg  <= CTRL_RST[1];
         period_reg  <= PERIOD_RST;
         pattern_reg <= '1;
      end else begin
         if (wr_ctrl)
            {invert_reg, enable_reg} <= wdata[1:0];
         if (wr_period)
            period_reg <= wdata;
         if (wr_pattern)
            pattern_reg <= wdata[LED_W-1:0];
      end
   end

   // Read mux feeding the SPI read shadow
   always_comb begin
      rdata = 8'h00;
      case (reg_addr)
         REG_CTRL:    rdata = {6'b0, invert_reg, enable_reg};
         REG_PERIOD:  rdata = period_reg;
         REG_PATTERN: rdata = pattern_ext;
         REG_VERSION: rdata = VERSION_VAL;
         default:     rdata = 8'h00;
      endcase
   end

   logic tick;
   assign tick = (presc_reg == PRESC_W'(TICK_DIV - 1));

   // Free-running 10 ms prescaler
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         presc_reg <= '0;
      else if (tick)
         presc_reg <= '0;
      else
         presc_reg <= presc_reg + 1'b1;
   end

   // A write landing on the same cycle as a tick takes effect first
   logic       enable_eff;
   logic [7:0] period_eff, hp_base, hp_last;
   assign enable_eff = wr_ctrl ? wdata[0] : enable_reg;
   assign period_eff = wr_period ? wdata : period_reg;
   assign hp_base    = wr_period ? 8'd0 : hp_reg;
   assign hp_last    = (period_eff == 8'd0) ? 8'd0 : period_eff - 8'd1;

   // Half-period counting and phase toggling
   always_comb begin
      hp_next    = hp_base;
      phase_next = phase_reg;
      if (!enable_eff) begin
         hp_next    = 8'd0;
         phase_next = 1'b0;
      end else if (tick) begin
         if (hp_base >= hp_last) begin
            hp_next    = 8'd0;
            phase_next = ~phase_reg;
         end else begin
            hp_next = hp_base + 8'd1;
         end
      end
   end

   // Blink state registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hp_reg    <= 8'd0;
         phase_reg <= 1'b0;
      end else begin
         hp_reg    <= hp_next;
         phase_reg <= phase_next;
      end
   end

   // Registered LED drive
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         led_reg <= '0;
      else
         led_reg <= (phase_reg ? pattern_reg : '0) ^ {LED_W{invert_reg}};
   end

   assign led = led_reg;

endmodule
